// File: rtl/ita_package.sv
// Shared requantisation types and default sizing for the ITA datapath.
package ita_package;

    localparam int unsigned N_PE             = 16;
    localparam int unsigned WO_BITS          = 26;
    localparam int unsigned WI_BITS          = 8;
    localparam int unsigned EMS_BITS         = 8;
    localparam int unsigned N_REQUANT_CONSTS = 6;

    // Clip mode of the final saturation stage.
    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

    // Constant tables and output lane type for the default configuration.
    typedef logic [N_REQUANT_CONSTS-1:0][EMS_BITS-1:0]       requant_const_array_t;
    typedef logic signed [N_REQUANT_CONSTS-1:0][WI_BITS-1:0] requant_array_t;
    typedef logic signed [WI_BITS-1:0]                       requant_oup_t;

    // Width of an index that selects one of n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ita_requant_lane.sv
// One requantisation lane: multiply, round-shift, add, clip over three enabled stages.
module ita_requant_lane
    import ita_package::*;
#(
    parameter int unsigned WO  = WO_BITS,
    parameter int unsigned WI  = WI_BITS,
    parameter int unsigned EMS = EMS_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en1_i,
    input  logic                 en2_i,
    input  logic                 en3_i,
    input  logic signed [WO-1:0] data_i,
    input  logic [EMS-1:0]       mult_i,
    input  logic [EMS-1:0]       shift_i,
    input  logic signed [WI-1:0] add_i,
    input  requant_mode_e        mode_i,
    output logic [WI-1:0]        data_o
);

    localparam int unsigned PW = WO + EMS + 1;  // exact product width
    localparam int unsigned RW = PW + 1;        // room for the rounding increment
    localparam int unsigned QW = RW + 1;        // room for the add

    localparam logic signed [QW-1:0] SMax = {{(QW-WI+1){1'b0}}, {(WI-1){1'b1}}};
    localparam logic signed [QW-1:0] SMin = {{(QW-WI+1){1'b1}}, {(WI-1){1'b0}}};
    localparam logic signed [QW-1:0] UMax = {{(QW-WI){1'b0}}, {WI{1'b1}}};

    logic signed [PW-1:0] prod_d, prod_q;
    logic [EMS-1:0]       shift_q;
    logic signed [WI-1:0] add1_q, add2_q;
    requant_mode_e        mode1_q, mode2_q;
    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] rnd_d, rnd_q;
    logic signed [QW-1:0] sum;
    logic [WI-1:0]        out_d, out_q;

    // Stage 1: signed data times zero-extended multiplier, exact in PW bits.
    always_comb begin
        prod_d = $signed({{(EMS+1){data_i[WO-1]}}, data_i}) * $signed({{(WO+1){1'b0}}, mult_i});
    end

    // Stage 2: round half up then arithmetic shift; oversized shifts flush to zero.
    always_comb begin
        rnd_sum = '0;
        rnd_d   = {prod_q[PW-1], prod_q};
        if (shift_q == '0) begin
            rnd_d = {prod_q[PW-1], prod_q};
        end else if (32'(shift_q) >= PW) begin
            rnd_d = '0;
        end else begin
            rnd_sum = {prod_q[PW-1], prod_q} + (RW'(1) << (shift_q - 1'b1));
            rnd_d   = rnd_sum >>> shift_q;
        end
    end

    // Stage 3: add the offset at full width, then saturate to the selected range.
    always_comb begin
        sum   = $signed({rnd_q[RW-1], rnd_q}) + $signed({{(QW-WI){add2_q[WI-1]}}, add2_q});
        out_d = sum[WI-1:0];
        if (mode2_q == Signed) begin
            if (sum > SMax) begin
                out_d = {1'b0, {(WI-1){1'b1}}};
            end else if (sum < SMin) begin
                out_d = {1'b1, {(WI-1){1'b0}}};
            end
        end else begin
            if (sum < 0) begin
                out_d = '0;
            end else if (sum > UMax) begin
                out_d = {WI{1'b1}};
            end
        end
    end

    // Stage registers, each loaded only when its stage advances with a valid beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q  <= '0;
            shift_q <= '0;
            add1_q  <= '0;
            mode1_q <= Signed;
            rnd_q   <= '0;
            add2_q  <= '0;
            mode2_q <= Signed;
            out_q   <= '0;
        end else begin
            if (en1_i) begin
                prod_q  <= prod_d;
                shift_q <= shift_i;
                add1_q  <= add_i;
                mode1_q <= mode_i;
            end
            if (en2_i) begin
                rnd_q   <= rnd_d;
                add2_q  <= add1_q;
                mode2_q <= mode1_q;
            end
            if (en3_i) begin
                out_q <= out_d;
            end
        end
    end

    assign data_o = out_q;

endmodule

// File: rtl/ita_requant_pipe.sv
// N-lane requantisation pipeline with a global stall and an output beat counter.
module ita_requant_pipe
    import ita_package::*;
#(
    parameter int unsigned N      = N_PE,
    parameter int unsigned WO     = WO_BITS,
    parameter int unsigned WI     = WI_BITS,
    parameter int unsigned EMS    = EMS_BITS,
    parameter int unsigned NSteps = N_REQUANT_CONSTS
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [N*WO-1:0]                data_i,
    input  logic [idx_width(NSteps)-1:0]   step_i,
    input  logic                           mode_i,
    input  logic                           last_i,
    input  logic [NSteps*EMS-1:0]          eps_mult_i,
    input  logic [NSteps*EMS-1:0]          right_shift_i,
    input  logic signed [NSteps*WI-1:0]    add_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [N*WI-1:0]                data_o,
    output logic                           last_o,
    output logic [31:0]                    beat_cnt_o
);

    logic                 en;
    int unsigned          sel_idx;
    logic [EMS-1:0]       mult_sel, shift_sel;
    logic signed [WI-1:0] add_sel;
    logic                 valid1_q, valid2_q, valid3_q;
    logic                 valid1_d, valid2_d, valid3_d;
    logic                 last1_q, last2_q, last3_q;
    logic                 last1_d, last2_d, last3_d;
    logic [31:0]          beat_cnt_d, beat_cnt_q;

    // Whole pipeline moves together; it only freezes when the output is blocked.
    assign en      = !valid3_q || ready_i;
    assign ready_o = en;

    // Pick the constant set; out-of-range steps fall back to set 0.
    always_comb begin
        sel_idx   = (32'(step_i) < NSteps) ? 32'(step_i) : 0;
        mult_sel  = eps_mult_i[sel_idx*EMS +: EMS];
        shift_sel = right_shift_i[sel_idx*EMS +: EMS];
        add_sel   = add_i[sel_idx*WI +: WI];
    end

    // Occupancy and last tags shift one stage per enabled cycle; bubbles stay bubbles.
    always_comb begin
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        valid3_d = valid3_q;
        last1_d  = last1_q;
        last2_d  = last2_q;
        last3_d  = last3_q;
        if (en) begin
            valid1_d = valid_i;
            valid2_d = valid1_q;
            valid3_d = valid2_q;
            last1_d  = valid_i && last_i;
            last2_d  = last1_q;
            last3_d  = last2_q;
        end
    end

    // Output beat counter; a handshaked last beat restarts the count.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (valid3_q && ready_i) begin
            beat_cnt_d = last3_q ? 32'd0 : beat_cnt_q + 32'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
            valid3_q   <= 1'b0;
            last1_q    <= 1'b0;
            last2_q    <= 1'b0;
            last3_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            valid1_q   <= valid1_d;
            valid2_q   <= valid2_d;
            valid3_q   <= valid3_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            last3_q    <= last3_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        ita_requant_lane #(
            .WO  (WO),
            .WI  (WI),
            .EMS (EMS)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en1_i   (en && valid_i),
            .en2_i   (en && valid1_q),
            .en3_i   (en && valid2_q),
            .data_i  (data_i[g*WO +: WO]),
            .mult_i  (mult_sel),
            .shift_i (shift_sel),
            .add_i   (add_sel),
            .mode_i  (requant_mode_e'(mode_i)),
            .data_o  (data_o[g*WI +: WI])
        );
    end

    assign valid_o    = valid3_q;
    assign last_o     = last3_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_ita_requant_pipe.sv
// Directed bench for ita_requant_pipe with hand-computed expected values.
module tb_ita_requant_pipe;

    localparam int unsigned N      = 16;
    localparam int unsigned WO     = 26;
    localparam int unsigned WI     = 8;
    localparam int unsigned EMS    = 8;
    localparam int unsigned NSteps = 6;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic                     valid_i;
    logic                     ready_o;
    logic [N*WO-1:0]          data_i;
    logic [2:0]               step_i;
    logic                     mode_i;
    logic                     last_i;
    logic [NSteps*EMS-1:0]    eps_mult_i;
    logic [NSteps*EMS-1:0]    right_shift_i;
    logic signed [NSteps*WI-1:0] add_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [N*WI-1:0]          data_o;
    logic                     last_o;
    logic [31:0]              beat_cnt_o;

    int n_total = 0;
    int n_bad   = 0;
    int cnt_exp = 0;

    always #5 clk = ~clk;

    ita_requant_pipe #(
        .N      (N),
        .WO     (WO),
        .WI     (WI),
        .EMS    (EMS),
        .NSteps (NSteps)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .step_i        (step_i),
        .mode_i        (mode_i),
        .last_i        (last_i),
        .eps_mult_i    (eps_mult_i),
        .right_shift_i (right_shift_i),
        .add_i         (add_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .last_o        (last_o),
        .beat_cnt_o    (beat_cnt_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*WI-1:0] rep(input logic [WI-1:0] v);
        return {N{v}};
    endfunction

    task automatic set_const(input int k, input int m, input int s, input int a);
        logic [EMS-1:0] mv;
        logic [EMS-1:0] sv;
        logic [WI-1:0]  av;
        mv = EMS'(m);
        sv = EMS'(s);
        av = WI'(a);
        eps_mult_i[k*EMS +: EMS]    = mv;
        right_shift_i[k*EMS +: EMS] = sv;
        add_i[k*WI +: WI]           = av;
    endtask

    // One beat through an empty pipeline; inputs are scrambled right after accept.
    task automatic run_beat(input string tag, input int d, input int step, input logic mode,
                            input logic last, input int exp);
        logic [WO-1:0]         dv;
        logic [WI-1:0]         ev;
        logic [NSteps*EMS-1:0] m_sv;
        logic [NSteps*EMS-1:0] s_sv;
        logic [NSteps*WI-1:0]  a_sv;
        int                    lat;
        dv = WO'(d);
        ev = WI'(exp);
        @(posedge clk); #1;
        valid_i = 1'b1;
        data_i  = {N{dv}};
        step_i  = 3'(step);
        mode_i  = mode;
        last_i  = last;
        @(negedge clk);
        check({tag, "_rdy"}, ready_o, 1'b1);
        @(posedge clk); #1;
        m_sv = eps_mult_i;
        s_sv = right_shift_i;
        a_sv = add_i;
        valid_i       = 1'b0;
        data_i        = ~data_i;
        step_i        = 3'd5;
        mode_i        = ~mode;
        last_i        = ~last;
        eps_mult_i    = ~eps_mult_i;
        right_shift_i = ~right_shift_i;
        add_i         = ~add_i;
        lat = 1;
        while (!valid_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, data_o, rep(ev));
        check({tag, "_last"}, last_o, last);
        @(posedge clk); #1;
        cnt_exp = last ? 0 : cnt_exp + 1;
        check({tag, "_bcnt"}, beat_cnt_o, cnt_exp);
        check({tag, "_drain"}, valid_o, 1'b0);
        eps_mult_i    = m_sv;
        right_shift_i = s_sv;
        add_i         = a_sv;
        mode_i        = 1'b0;
        last_i        = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_bcnt", beat_cnt_o, 32'd0);
        cnt_exp = 0;
    endtask

    initial begin
        logic [WO-1:0]  dv;
        logic [WI-1:0]  ev;
        logic [N*WI-1:0] hold_val;
        logic           held;
        int             sent;
        int             got;
        int             stale;

        rst_i         = 1'b1;
        valid_i       = 1'b0;
        ready_i       = 1'b1;
        data_i        = '0;
        step_i        = '0;
        mode_i        = 1'b0;
        last_i        = 1'b0;
        eps_mult_i    = '0;
        right_shift_i = '0;
        add_i         = '0;
        set_const(0, 5, 2, 0);
        set_const(1, 1, 1, 0);
        set_const(2, 1, 0, 0);
        set_const(3, 3, 4, -5);
        set_const(4, 255, 40, 7);
        set_const(5, 200, 3, 10);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, '0);
        check("rst_last", last_o, 1'b0);
        check("rst_cnt", beat_cnt_o, 32'd0);
        rst_i = 1'b0;
        #1;
        check("rst_ready", ready_o, 1'b1);

        // Single-beat arithmetic.
        run_beat("basic", 100, 0, 1'b0, 1'b0, 125);
        run_beat("neg_s", -7, 1, 1'b0, 1'b0, -3);
        run_beat("neg_u", -7, 1, 1'b1, 1'b0, 0);
        run_beat("sat_s", 300, 2, 1'b0, 1'b0, 127);
        run_beat("sat_u", 300, 2, 1'b1, 1'b0, 255);
        run_beat("sat_n", -300, 2, 1'b0, 1'b0, -128);
        run_beat("rnd_half", 5, 1, 1'b0, 1'b0, 3);
        run_beat("add_s", 1000, 3, 1'b0, 1'b0, 127);
        run_beat("add_u", 1000, 3, 1'b1, 1'b0, 183);
        run_beat("add_n", -50, 3, 1'b0, 1'b0, -14);
        run_beat("big_shift", -12345, 4, 1'b0, 1'b0, 7);
        run_beat("m200_u", -3, 5, 1'b1, 1'b0, 0);
        run_beat("m200_s", -3, 5, 1'b0, 1'b0, -65);

        // Back-to-back stream with ready_i low in cycles 4-6.
        sent = 0;
        got  = 0;
        held = 1'b0;
        hold_val = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            ready_i = !(cyc >= 4 && cyc <= 6);
            if (sent < 10) begin
                valid_i = 1'b1;
                dv      = WO'(sent * 10 + 1);
                data_i  = {N{dv}};
                step_i  = 3'd2;
                mode_i  = 1'b0;
                last_i  = 1'b0;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (valid_i && ready_o) sent++;
            if (held) check("stall_hold", {valid_o, data_o}, {1'b1, hold_val});
            held = 1'b0;
            if (valid_o) begin
                if (ready_i) begin
                    ev = WI'(got * 10 + 1);
                    check("stream_data", data_o, rep(ev));
                    got++;
                    cnt_exp++;
                end else begin
                    held     = 1'b1;
                    hold_val = data_o;
                end
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("stream_sent", sent, 10);
        check("stream_got", got, 10);
        check("stream_bcnt", beat_cnt_o, cnt_exp);

        // Last tagging and beat counter restart; step 7 falls back to set 0.
        do_reset();
        run_beat("tag1", 10, 2, 1'b0, 1'b0, 10);
        run_beat("tag2", 20, 2, 1'b0, 1'b0, 20);
        run_beat("tag3", 30, 2, 1'b0, 1'b1, 30);
        run_beat("step7", 100, 7, 1'b0, 1'b0, 125);

        // Reset with three beats in flight.
        @(posedge clk); #1;
        valid_i = 1'b1;
        step_i  = 3'd2;
        mode_i  = 1'b0;
        last_i  = 1'b1;
        dv      = WO'(40);
        data_i  = {N{dv}};
        for (int b = 1; b < 3; b++) begin
            @(posedge clk); #1;
            last_i = 1'b0;
            dv     = WO'(40 + b);
            data_i = {N{dv}};
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("pre_rst_valid", valid_o, 1'b1);
        check("pre_rst_last", last_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_data", data_o, '0);
        check("mid_rst_last", last_o, 1'b0);
        check("mid_rst_cnt", beat_cnt_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", ready_o, 1'b1);
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (valid_o) stale++;
        end
        check("no_stale", stale, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
